cordic_sched: RTL and testbench
===============================

# cordic_sched

Round-robin scheduler that shares a single CORDIC sin/cos core among `N_REQ` requesters. It accepts degree requests (0–359, Q9.0) and issues them to the core one at a time. It captures the Q2.10 cos/sin results on the core's one-cycle `done` pulse and returns each result on a tagged response channel with a valid/ready handshake. It sits between the client blocks and the CORDIC core, and is the only driver of the core's `start` and `degree` inputs.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `ID_W`, 2, width of the response id; must satisfy 2^ID_W ≥ N_REQ
- `TIMEOUT`, 32, maximum WAIT cycles before a pending job is abandoned

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  N_REQ  per-requester request; held until accepted
- `req_degree`  in  9*N_REQ  per-requester angle; slice i is [9i+8:9i]; held with `req_valid`
- `req_ready`  out  N_REQ  one-hot, one-cycle accept pulse
- `core_start`  out  1  start pulse to the CORDIC core
- `core_degree`  out  9  angle to the core; held stable from ISSUE until RESP
- `core_cos`, `core_sin`  in  12 each  signed Q2.10 core results; valid only while `core_done`=1
- `core_done`  in  1  one-cycle core completion pulse
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  consumer accepts the response
- `rsp_id`  out  ID_W  index of the requester that owns the response
- `rsp_cos`, `rsp_sin`  out  12 each  signed Q2.10 results
- `rsp_err`  out  1  job failed (timeout or range error)

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- Reset values: `req_ready`=0, `core_start`=0, `core_degree`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_cos`=0, `rsp_sin`=0, `rsp_err`=0. The round-robin pointer `ptr` resets to 0.
- IDLE:
  - If any `req_valid` is set, the winner is the first set bit searching from `ptr` upward, with wrap-around.
  - `req_ready[winner]`=1 for that cycle; the id and degree are latched.
  - Next state is ISSUE. If no request is valid, the FSM stays in IDLE.
- ISSUE: `core_start`=1 for exactly one cycle, with `core_degree` equal to the latched degree. Next state is WAIT. The WAIT-cycle counter clears.
- WAIT:
  - The counter increments each cycle.
  - On `core_done`: register `core_cos`/`core_sin` into `rsp_cos`/`rsp_sin`, set `rsp_err`=0, go to RESP.
  - If the counter reaches TIMEOUT with no `core_done`: set `rsp_cos`=`rsp_sin`=0, `rsp_err`=1, go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_id`, `rsp_cos`, `rsp_sin` and `rsp_err` are held stable.
  - On `rsp_valid && rsp_ready`: `ptr` = (winner+1) mod N_REQ, next state IDLE, `rsp_valid` drops the next cycle.
- Only one job is in flight at a time. No new request is accepted until the response handshake completes.
- A `core_done` arriving outside WAIT is ignored.
- A requester that drops `req_valid` before acceptance is simply not granted. This is legal.
- Reset asserted mid-job returns the FSM to IDLE and clears all outputs immediately. The core must be reset with the same event (the core reset is active-high; the top level inverts `rst_n`).

## Timing
- Core contract: the core samples `degree` and `start` in the same cycle. Its `done` pulse arrives 20 cycles after the `start` cycle: 1 convert cycle, 16 rotate cycles, 1 multiply cycle, 1 round cycle, then DONE.
- Let cycle 0 be the `req_ready` cycle:
  - ISSUE is cycle 1.
  - `core_done` arrives in cycle 21.
  - `rsp_valid` rises in cycle 22.
- Earliest next accept is the cycle after the response handshake.
- Back-to-back throughput is one job per 23 cycles when `rsp_ready` is tied high.
- The response is registered; there are no combinational paths from `core_*` to `rsp_*`.

## Configuration
- `CORDIC_SCHED_RANGE_CHECK_EN` defined:
  - A latched degree ≥ 360 skips ISSUE and WAIT: IDLE goes directly to RESP with `rsp_err`=1 and `rsp_cos`=`rsp_sin`=0.
  - The response appears 1 cycle after accept, and the core is never started.
- Not defined: a degree ≥ 360 is reduced by subtracting 360 at latch time, and the job runs normally. Example: 400 runs as 40.

## Test plan
- Single request, requester 0, degree 0 → `rsp_valid` at cycle 22, `rsp_id`=0, `rsp_cos`=0x400 ±1, `rsp_sin`=0x000 ±1, `rsp_err`=0.
- Requester 2, degree 180 → `rsp_id`=2, `rsp_cos`=0xC00 ±1, `rsp_sin`=0x000 ±1.
- All 4 `req_valid` held high with `rsp_ready`=1 → grant order 0,1,2,3,0; `req_ready` is one-hot with exactly one pulse per accept.
- Core `done` suppressed → `rsp_err`=1, `rsp_cos`=`rsp_sin`=0 after TIMEOUT WAIT cycles; the next request then completes normally.
- `rsp_ready` held low for 10 cycles → `rsp_valid` and the payload are held stable; no `req_ready` or `core_start` is asserted in that window.
- Degree 400: with the macro, `rsp_err`=1 one cycle after accept and `core_start` never asserts; without it, the result matches degree 40 (cos≈0x310, sin≈0x292 ±1).

Source files
------------

// File: rtl/cordic_sched_if.sv
// cordic_sched_if: bundles the request, core and response channels of the
// CORDIC scheduler. The slave modport is the scheduler's view; the master
// modport is the view of the clients plus the CORDIC core around it.
interface cordic_sched_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) ();
  // Request side: one valid/degree slot per requester, one-hot accept.
  logic [N_REQ-1:0]   req_valid;
  logic [9*N_REQ-1:0] req_degree;
  logic [N_REQ-1:0]   req_ready;

  // Core side: start pulse with angle out, completion pulse with results in.
  logic               core_start;
  logic [8:0]         core_degree;
  logic signed [11:0] core_cos;
  logic signed [11:0] core_sin;
  logic               core_done;

  // Tagged response channel.
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic signed [11:0] rsp_cos;
  logic signed [11:0] rsp_sin;
  logic               rsp_err;

  modport slave (
    input  req_valid, req_degree, core_cos, core_sin, core_done, rsp_ready,
    output req_ready, core_start, core_degree,
           rsp_valid, rsp_id, rsp_cos, rsp_sin, rsp_err
  );

  modport master (
    output req_valid, req_degree, core_cos, core_sin, core_done, rsp_ready,
    input  req_ready, core_start, core_degree,
           rsp_valid, rsp_id, rsp_cos, rsp_sin, rsp_err
  );
endinterface

// File: rtl/cordic_sched.sv
// cordic_sched: round-robin scheduler sharing one CORDIC sin/cos core among
// N_REQ requesters. One job in flight; results are registered and returned
// on a tagged valid/ready response channel.
// Optional feature macro: CORDIC_SCHED_RANGE_CHECK_EN -- when defined, an
// angle >= 360 is answered immediately with rsp_err=1 and never reaches the
// core; when undefined, such an angle is folded by subtracting 360.
// The CORDIC core must be reset by the same event (active-high, ~rst_n).
module cordic_sched #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 32
) (
  input logic           clk,
  input logic           rst_n,
  cordic_sched_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [CNT_W-1:0]   wait_cnt;
  logic               core_start;
  logic [8:0]         core_degree;
  logic               rsp_valid;
  logic [ID_W-1:0]    rsp_id;
  logic signed [11:0] rsp_cos;
  logic signed [11:0] rsp_sin;
  logic               rsp_err;

  logic               any_valid;
  logic [ID_W-1:0]    win_id;
  logic [N_REQ-1:0]   win_onehot;
  logic [8:0]         win_degree;
  int                 scan_idx;

  // Round-robin search from ptr upward with wrap; scanning high-to-low offset
  // lets the nearest set bit overwrite any farther one.
  always_comb begin
    any_valid = 1'b0;
    win_id    = '0;
    scan_idx  = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_idx = (int'(ptr) + k) % N_REQ;
      if (bus.req_valid[scan_idx]) begin
        any_valid = 1'b1;
        win_id    = ID_W'(scan_idx);
      end
    end
    win_onehot = any_valid ? (N_REQ'(1) << win_id) : '0;
    win_degree = bus.req_degree[9*win_id +: 9];
  end

  // The accept pulse is decided in the IDLE cycle itself so that a requester
  // which drops req_valid is never granted; it is held low during reset.
  assign bus.req_ready = (state == IDLE && rst_n) ? win_onehot : '0;

  // Scheduler FSM with all core and response outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      wait_cnt    <= '0;
      core_start  <= 1'b0;
      core_degree <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_cos     <= '0;
      rsp_sin     <= '0;
      rsp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            rsp_id <= win_id;
`ifdef CORDIC_SCHED_RANGE_CHECK_EN
            if (win_degree >= 9'd360) begin
              rsp_cos   <= '0;
              rsp_sin   <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              core_degree <= win_degree;
              core_start  <= 1'b1;
              state       <= ISSUE;
            end
`else
            core_degree <= (win_degree >= 9'd360) ? (win_degree - 9'd360) : win_degree;
            core_start  <= 1'b1;
            state       <= ISSUE;
`endif
          end
        end
        ISSUE: begin
          core_start <= 1'b0;
          wait_cnt   <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (bus.core_done) begin
            rsp_cos   <= bus.core_cos;
            rsp_sin   <= bus.core_sin;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            rsp_cos   <= '0;
            rsp_sin   <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= (rsp_id == ID_W'(N_REQ - 1)) ? '0 : rsp_id + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.core_start  = core_start;
  assign bus.core_degree = core_degree;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_id      = rsp_id;
  assign bus.rsp_cos     = rsp_cos;
  assign bus.rsp_sin     = rsp_sin;
  assign bus.rsp_err     = rsp_err;

endmodule

// File: tb/tb_cordic_sched.sv
// tb_cordic_sched: directed bench for cordic_sched with a behavioural CORDIC
// core (done 20 cycles after start, results from a small angle table).
// Build with or without CORDIC_SCHED_RANGE_CHECK_EN; expectations follow.
module tb_cordic_sched;
  localparam int N_REQ   = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cordic_sched_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

  cordic_sched #(.N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural core: samples degree with start, pulses done 20 cycles later.
  logic [4:0] core_rem;
  logic [8:0] core_deg;
  logic       core_done_r;
  logic       core_mute = 1'b0;
  int         start_cnt = 0;

  function automatic logic [23:0] lut(input logic [8:0] d);
    case (d)
      9'd0:    lut = {12'h400, 12'h000};
      9'd40:   lut = {12'h310, 12'h292};
      9'd90:   lut = {12'h000, 12'h400};
      9'd180:  lut = {12'hC00, 12'h000};
      9'd270:  lut = {12'h000, 12'hC00};
      default: lut = {3'b000, d, 3'b111, ~d};
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rem    <= '0;
      core_deg    <= '0;
      core_done_r <= 1'b0;
    end else begin
      core_done_r <= 1'b0;
      if (bus.core_start) begin
        core_deg <= bus.core_degree;
        core_rem <= 5'd19;
      end else if (core_rem != 0) begin
        core_rem <= core_rem - 1'b1;
        if (core_rem == 5'd1 && !core_mute) core_done_r <= 1'b1;
      end
    end
  end

  always @(posedge clk) if (bus.core_start === 1'b1) start_cnt++;

  assign bus.core_done = core_done_r;
  assign {bus.core_cos, bus.core_sin} = core_done_r ? lut(core_deg) : 24'h5A5A5A;

  // Stimulus helper: present one request, release it after acceptance and
  // report the accept vector and the cycles until rsp_valid (-1 on no answer).
  task automatic run_job(input int id, input logic [8:0] deg,
                         output int lat, output logic [N_REQ-1:0] grant);
    @(negedge clk);
    bus.req_degree[9*id +: 9] = deg;
    bus.req_valid = N_REQ'(1) << id;
    #1 grant = bus.req_ready;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = '0;
      if (bus.rsp_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = '1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready);
    end
    checks++;
    if ({bus.core_start, bus.core_degree, bus.rsp_valid, bus.rsp_id,
         bus.rsp_cos, bus.rsp_sin, bus.rsp_err} !== 38'd0) begin
      errors++;
      $display("FAIL reset_outputs: got start=%b deg=%0d rv=%b id=%0d cos=%h sin=%h err=%b expected all 0",
               bus.core_start, bus.core_degree, bus.rsp_valid, bus.rsp_id,
               bus.rsp_cos, bus.rsp_sin, bus.rsp_err);
    end
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single(input int id, input logic [8:0] deg,
                             input logic [11:0] exp_cos, input logic [11:0] exp_sin);
    int lat;
    logic [N_REQ-1:0] grant;
    int starts0;
    starts0 = start_cnt;
    run_job(id, deg, lat, grant);
    checks++;
    if (grant !== (N_REQ'(1) << id)) begin
      errors++; $display("FAIL single_grant: got %b expected %b", grant, N_REQ'(1) << id);
    end
    checks++;
    if (lat != 22) begin
      errors++; $display("FAIL single_latency: got %0d expected 22", lat);
    end
    checks++;
    if ({bus.rsp_id, bus.rsp_cos, bus.rsp_sin, bus.rsp_err} !== {ID_W'(id), exp_cos, exp_sin, 1'b0}) begin
      errors++;
      $display("FAIL single_payload: got id=%0d cos=%h sin=%h err=%b expected id=%0d cos=%h sin=%h err=0",
               bus.rsp_id, bus.rsp_cos, bus.rsp_sin, bus.rsp_err, id, exp_cos, exp_sin);
    end
    checks++;
    if (start_cnt - starts0 != 1) begin
      errors++; $display("FAIL single_starts: got %0d expected 1", start_cnt - starts0);
    end
    handshake();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_rsp_drop: got %b expected 0", bus.rsp_valid);
    end
    $display("single: id=%0d deg=%0d lat=%0d cos=%h sin=%h", id, deg, lat, bus.rsp_cos, bus.rsp_sin);
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    int g = 0;
    int last = 0;
    int starts0;
    starts0 = start_cnt;
    @(negedge clk);
    bus.req_degree = '0;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 200 && g < 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (bus.req_ready !== '0) begin
        checks++;
        if (bus.req_ready !== (N_REQ'(1) << order[g])) begin
          errors++; $display("FAIL rr_grant%0d: got %b expected %b", g, bus.req_ready, N_REQ'(1) << order[g]);
        end
        if (g > 0) begin
          checks++;
          if (c - last != 23) begin
            errors++; $display("FAIL rr_spacing%0d: got %0d expected 23", g, c - last);
          end
        end
        $display("rr: grant %0d -> %b at cycle %0d", g, bus.req_ready, c);
        last = c;
        g++;
      end
    end
    @(negedge clk);
    bus.req_valid = '0;
    checks++;
    if (g != 5) begin
      errors++; $display("FAIL rr_count: got %0d expected 5", g);
    end
    repeat (30) @(negedge clk);
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || start_cnt - starts0 != 5) begin
      errors++; $display("FAIL rr_drain: got rsp_valid=%b starts=%0d expected 0 and 5",
                         bus.rsp_valid, start_cnt - starts0);
    end
  endtask

  task automatic test_timeout();
    int lat;
    logic [N_REQ-1:0] grant;
    core_mute = 1'b1;
    run_job(1, 9'd270, lat, grant);
    checks++;
    // WAIT starts the cycle after the start pulse and lasts TIMEOUT cycles.
    if (lat != TIMEOUT + 2) begin
      errors++; $display("FAIL timeout_latency: got %0d expected %0d", lat, TIMEOUT + 2);
    end
    checks++;
    if ({bus.rsp_id, bus.rsp_cos, bus.rsp_sin, bus.rsp_err} !== {2'd1, 12'h000, 12'h000, 1'b1}) begin
      errors++; $display("FAIL timeout_payload: got id=%0d cos=%h sin=%h err=%b expected id=1 cos=000 sin=000 err=1",
                         bus.rsp_id, bus.rsp_cos, bus.rsp_sin, bus.rsp_err);
    end
    $display("timeout: lat=%0d err=%b", lat, bus.rsp_err);
    handshake();
    core_mute = 1'b0;
    run_job(2, 9'd40, lat, grant);
    checks++;
    if (lat != 22 || {bus.rsp_id, bus.rsp_cos, bus.rsp_sin, bus.rsp_err} !== {2'd2, 12'h310, 12'h292, 1'b0}) begin
      errors++; $display("FAIL timeout_recover: got lat=%0d id=%0d cos=%h sin=%h err=%b expected 22 2 310 292 0",
                         lat, bus.rsp_id, bus.rsp_cos, bus.rsp_sin, bus.rsp_err);
    end
    $display("recover: lat=%0d cos=%h sin=%h", lat, bus.rsp_cos, bus.rsp_sin);
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [N_REQ-1:0] grant;
    int starts0;
    run_job(3, 9'd90, lat, grant);
    starts0 = start_cnt;
    bus.req_degree[8:0]  = 9'd0;
    bus.req_degree[17:9] = 9'd0;
    bus.req_valid = 4'b0011;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_cos, bus.rsp_sin, bus.rsp_err} !==
          {1'b1, 2'd3, 12'h000, 12'h400, 1'b0} || bus.req_ready !== '0 || bus.core_start !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d: got rv=%b id=%0d cos=%h sin=%h err=%b rdy=%b start=%b expected 1 3 000 400 0 0000 0",
                 c, bus.rsp_valid, bus.rsp_id, bus.rsp_cos, bus.rsp_sin, bus.rsp_err,
                 bus.req_ready, bus.core_start);
      end
      @(negedge clk);
    end
    bus.req_valid = '0;
    handshake();
    checks++;
    if (start_cnt != starts0 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL hold_release: got starts=%0d rv=%b expected %0d 0", start_cnt, bus.rsp_valid, starts0);
    end
    $display("backpressure: held 10 cycles, id=3");
  endtask

  task automatic test_range();
    int lat;
    logic [N_REQ-1:0] grant;
    int starts0;
    starts0 = start_cnt;
    run_job(0, 9'd400, lat, grant);
`ifdef CORDIC_SCHED_RANGE_CHECK_EN
    checks++;
    if (lat != 1 || {bus.rsp_cos, bus.rsp_sin, bus.rsp_err} !== {12'h000, 12'h000, 1'b1}) begin
      errors++; $display("FAIL range_reject: got lat=%0d cos=%h sin=%h err=%b expected 1 000 000 1",
                         lat, bus.rsp_cos, bus.rsp_sin, bus.rsp_err);
    end
    handshake();
    repeat (25) @(negedge clk);
    checks++;
    if (start_cnt != starts0) begin
      errors++; $display("FAIL range_no_start: got %0d starts expected 0", start_cnt - starts0);
    end
`else
    checks++;
    if (lat != 22 || bus.core_degree !== 9'd40 ||
        {bus.rsp_cos, bus.rsp_sin, bus.rsp_err} !== {12'h310, 12'h292, 1'b0}) begin
      errors++; $display("FAIL range_fold: got lat=%0d deg=%0d cos=%h sin=%h err=%b expected 22 40 310 292 0",
                         lat, bus.core_degree, bus.rsp_cos, bus.rsp_sin, bus.rsp_err);
    end
    checks++;
    if (start_cnt - starts0 != 1) begin
      errors++; $display("FAIL range_starts: got %0d expected 1", start_cnt - starts0);
    end
    handshake();
`endif
    $display("range: deg=400 lat=%0d err=%b", lat, bus.rsp_err);
  endtask

  task automatic test_reset_mid_job();
    bit seen = 0;
    @(negedge clk);
    bus.req_degree[17:9] = 9'd90;
    bus.req_valid = 4'b0010;
    @(negedge clk);
    bus.req_valid = '0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.core_start, bus.core_degree, bus.rsp_valid, bus.rsp_id,
         bus.rsp_cos, bus.rsp_sin, bus.rsp_err} !== 38'd0) begin
      errors++; $display("FAIL midreset_outputs: got deg=%0d rv=%b id=%0d expected all 0",
                         bus.core_degree, bus.rsp_valid, bus.rsp_id);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL midreset_stale_rsp: got rsp_valid=1 expected 0");
    end
    $display("midreset: aborted job, no stale response");
    test_single(1, 9'd90, 12'h000, 12'h400);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = '0;
    bus.req_degree = '0;
    bus.rsp_ready  = 1'b0;
    test_reset();
    test_single(0, 9'd0,   12'h400, 12'h000);
    test_single(2, 9'd180, 12'hC00, 12'h000);
    test_single(3, 9'd90,  12'h000, 12'h400);
    test_round_robin();
    test_timeout();
    test_backpressure();
    test_range();
    test_reset_mid_job();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
